mem_stage_sram_ctrl: RTL
========================

Name: mem_stage_sram_ctrl

Overview:
- Memory-access stage of the 5-stage ARM pipeline; sits between EXE stage register and MEM stage register.
- Performs 32-bit word loads/stores to an external 16-bit asynchronous SRAM as two half-word phases with programmable wait states.
- Drives `ready` low to freeze the pipeline while an access is in flight.
- `mem_read_value` feeds the MEM stage register's memory-read-value input.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 1: cycles per half-word phase; legal range 1..15.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- mem_read_en  input  1  load request from EXE stage register
- mem_write_en  input  1  store request from EXE stage register
- alu_result  input  32  byte address of access
- val_rm  input  32  store data
- mem_read_value  output  32  last completed load data
- ready  output  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline
- sram_addr  output  SRAM_AW  half-word address
- sram_dq_out  output  16  write data to SRAM
- sram_dq_in  input  16  read data from SRAM
- sram_dq_oe  output  1  1 = drive sram_dq_out onto bus
- sram_we_n  output  1  active-low write strobe
- sram_oe_n  output  1  active-low output enable

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk, rising edge. On reset:
  - state=IDLE, phase counter=0, mem_read_value=0, sram_addr=0, sram_dq_out=0.
  - sram_dq_oe=0, sram_we_n=1, sram_oe_n=1.
  - ready=1 (combinational, IDLE with no request).
- Address mapping:
  - word = (alu_result - BASE_ADDR) >> 2, 32-bit unsigned subtract, wraps.
  - Low half address = {word, 0}; high half address = {word, 1}.
  - Both truncated to SRAM_AW bits. Byte offset bits [1:0] ignored.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if mem_write_en or mem_read_en, go to LOW and load counter = WAIT_CYCLES-1; otherwise stay in IDLE.
  - LOW: counter decrements each cycle; at counter==0, go to HIGH and reload counter.
  - HIGH: at counter==0, go to DONE.
  - DONE: always go to IDLE.
- ready:
  - 1 in IDLE with no request, and in DONE.
  - 0 in IDLE with a request, and in LOW and HIGH.
  - Freeze length is 1 + 2*WAIT_CYCLES cycles.
  - Pipeline advances on the DONE cycle. The next instruction's request is seen in the following IDLE cycle.
- Inputs are held stable by the freeze; the controller samples them combinationally each cycle and does not latch them.
- Read (mem_read_en=1, mem_write_en=0):
  - sram_oe_n=0 during LOW and HIGH; sram_addr = low or high half address per phase.
  - sram_dq_in captured into internal low/high registers on the last cycle of each phase (counter==0).
  - mem_read_value = {high, low} updates at the HIGH→DONE edge, so it is valid in DONE.
  - mem_read_value holds until the next load completes; stores never change it.
- Write (mem_write_en=1):
  - sram_dq_oe=1 and sram_we_n=0 during LOW and HIGH.
  - sram_dq_out = val_rm[15:0] in LOW, val_rm[31:16] in HIGH.
  - sram_addr stable for the full phase.
  - sram_oe_n stays 1.
- Both enables set: treated as a write.
- In IDLE and DONE: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0.
- Reset mid-access: immediate return to IDLE. No continuation of a partial write; the half-word already written stays in SRAM. Partial read data is discarded and mem_read_value=0.
- All SRAM control outputs are registered-state decoded, with no glitch-sensitive combinational paths from inputs to sram_we_n.

Test Plan:
- Reset idle: assert rst, release with no requests → ready=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, mem_read_value=0.
- Store, WAIT_CYCLES=1: alu_result=1024, val_rm=0xDEADBEEF, mem_write_en=1 → ready=0 for 3 cycles then 1. LOW cycle: sram_addr=0, sram_dq_out=0xBEEF, we_n=0. HIGH cycle: sram_addr=1, sram_dq_out=0xDEAD.
- Load: model SRAM preloaded; alu_result=1028, mem_read_en=1 → sram_addr 2 then 3, oe_n=0. In DONE, mem_read_value = SRAM contents (e.g. 0xCAFEF00D), ready=1.
- Wait states: WAIT_CYCLES=3, load at 1032 → ready low exactly 7 cycles; each half address held 3 cycles; data sampled on the 3rd cycle of each phase.
- Back-to-back: store to 1024 followed immediately by load from 1024 → second access starts in the IDLE after DONE; load returns 0xDEADBEEF. A store between loads leaves mem_read_value unchanged.
- Reset mid-write: assert rst during HIGH phase → next observation shows IDLE outputs, ready=1, mem_read_value=0; a subsequent load at 1024 returns the new low half and the old high half.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl
// Memory-access stage of the 5-stage pipeline. A 32-bit word load or store is
// carried out on a 16-bit asynchronous SRAM as two half-word phases (low half
// first, then high half). Each phase lasts WAIT_CYCLES clock cycles.
//
// Handshake: ready is a stall signal toward the pipeline. ready=1 means either
// nothing is requested (IDLE) or the access completes this cycle (DONE), so
// the pipeline registers may advance on this edge. ready=0 freezes the pipeline.
// Because the pipeline is frozen, mem_read_en/mem_write_en/alu_result/val_rm
// stay stable for the whole access. The controller reads them every cycle and
// does not hold its own copy of the address or the store data.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mem_read_en       load request
//   mem_write_en      store request (takes priority over a load)
//   alu_result        byte address of the access
//   val_rm            store data
//   mem_read_value    data from the last completed load, valid from DONE onward
//   ready             0 = freeze pipeline
//   sram_addr         half-word address (registered)
//   sram_dq_out       write data (registered)
//   sram_dq_in        read data from the SRAM
//   sram_dq_oe        1 = drive sram_dq_out onto the bus
//   sram_we_n         active-low write strobe
//   sram_oe_n         active-low output enable
//   dbg_state         current FSM state (0 IDLE, 1 LOW, 2 HIGH, 3 DONE)
module mem_stage_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 1,   // legal range 1..15
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read_en,
  input  logic               mem_write_en,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        val_rm,
  output logic [31:0]        mem_read_value,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(WAIT_CYCLES - 1);

  state_t             state, state_nx;
  logic [3:0]         cnt, cnt_nx;
  logic               is_wr, is_wr_nx;
  logic [SRAM_AW-1:0] addr_q, addr_nx;
  logic [15:0]        dq_q, dq_nx;
  logic [15:0]        low_q, low_nx;
  logic [31:0]        rd_q, rd_nx;

  logic               req;
  logic               active;
  logic [31:0]        offset;
  logic [SRAM_AW-1:0] lo_addr;
  logic [SRAM_AW-1:0] hi_addr;
  logic               unused_addr_bits;

  // The subtraction wraps, so addresses below BASE_ADDR map to the top of
  // the SRAM. Byte-offset bits and word bits above the SRAM size are dropped.
  assign offset  = alu_result - BASE_ADDR;
  assign lo_addr = {offset[SRAM_AW:2], 1'b0};
  assign hi_addr = {offset[SRAM_AW:2], 1'b1};
  assign unused_addr_bits = ^{offset[1:0], offset[31:SRAM_AW+1]};

  assign req = mem_read_en | mem_write_en;

  // State register and the registered SRAM address/data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      is_wr  <= 1'b0;
      addr_q <= '0;
      dq_q   <= 16'd0;
      low_q  <= 16'd0;
      rd_q   <= 32'd0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      is_wr  <= is_wr_nx;
      addr_q <= addr_nx;
      dq_q   <= dq_nx;
      low_q  <= low_nx;
      rd_q   <= rd_nx;
    end
  end

  // Next-state logic. The address and data for each phase are loaded on
  // entry to that phase, so the SRAM sees them stable for the whole phase.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    is_wr_nx = is_wr;
    addr_nx  = addr_q;
    dq_nx    = dq_q;
    low_nx   = low_q;
    rd_nx    = rd_q;
    case (state)
      IDLE: begin
        if (req) begin
          state_nx = LOW;
          cnt_nx   = CNT_RELOAD;
          is_wr_nx = mem_write_en;
          addr_nx  = lo_addr;
          dq_nx    = val_rm[15:0];
        end
      end
      LOW: begin
        if (cnt == 4'd0) begin
          state_nx = HIGH;
          cnt_nx   = CNT_RELOAD;
          addr_nx  = hi_addr;
          dq_nx    = val_rm[31:16];
          if (!is_wr) low_nx = sram_dq_in;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      HIGH: begin
        if (cnt == 4'd0) begin
          state_nx = DONE;
          if (!is_wr) rd_nx = {sram_dq_in, low_q};
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // SRAM strobes depend only on registered state. No input reaches them, so
  // they cannot glitch.
  assign active      = (state == LOW) || (state == HIGH);
  assign sram_we_n   = ~(active & is_wr);
  assign sram_oe_n   = ~(active & ~is_wr);
  assign sram_dq_oe  = active & is_wr;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;

  assign ready          = ((state == IDLE) && !req) || (state == DONE);
  assign mem_read_value = rd_q;
  assign dbg_state      = state;

endmodule
